// File: rtl/dht11_scheduler.sv
// Read sequencer for dht11_controller: periodic/on-demand triggering, holdoff,
// timeout and bounded retry, and a latched copy of the last good reading.
module dht11_scheduler #(
    parameter int unsigned PERIOD_CYC  = 200_000_000,
    parameter int unsigned TIMEOUT_CYC = 3_000_000,
    parameter int unsigned GAP_CYC     = 100_000_000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        req,
    output logic        dht_start,
    input  logic        dht_done,
    input  logic        dht_valid,
    input  logic [15:0] dht_humidity,
    input  logic [15:0] dht_temperature,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        data_valid,
    output logic        update,
    output logic        error,
    output logic [7:0]  err_count,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3
    } state_t;

    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] GAP_LOAD     = 32'(GAP_CYC);
    localparam logic [31:0] RETRY_MAX    = 32'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] retry_q, retry_d;
    logic        pending_q, pending_d;
    logic        retry_pend_q, retry_pend_d;
    logic        dht_start_q, dht_start_d;
    logic [15:0] humidity_q, humidity_d;
    logic [15:0] temperature_q, temperature_d;
    logic        data_valid_q, data_valid_d;
    logic        update_q, update_d;
    logic        error_q, error_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        busy_q, busy_d;
    logic        period_hit;
    logic        attempt_end;

    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        tmo_d         = tmo_q;
        hold_d        = hold_q;
        retry_d       = retry_q;
        pending_d     = pending_q;
        retry_pend_d  = retry_pend_q;
        dht_start_d   = 1'b0;
        humidity_d    = humidity_q;
        temperature_d = temperature_q;
        data_valid_d  = data_valid_q;
        update_d      = 1'b0;
        error_d       = 1'b0;
        err_count_d   = err_count_q;
        attempt_end   = 1'b0;

        period_hit = enable && (period_q == PERIOD_LAST);
        if (!enable || period_hit) begin
            period_d = '0;
        end else begin
            period_d = period_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d   = 1'b0;
                    dht_start_d = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                tmo_d   = TIMEOUT_LAST;
                state_d = WAIT;
            end
            WAIT: begin
                // A done pulse on the expiry cycle takes precedence over the timeout.
                attempt_end = dht_done || (tmo_q == '0);
                if (dht_done && dht_valid) begin
                    humidity_d    = dht_humidity;
                    temperature_d = dht_temperature;
                    update_d      = 1'b1;
                    data_valid_d  = 1'b1;
                    retry_d       = '0;
                end else if (attempt_end) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d      = retry_q + 32'd1;
                        retry_pend_d = 1'b1;
                    end else begin
                        error_d     = 1'b1;
                        retry_d     = '0;
                        err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
                    end
                end
                if (attempt_end) begin
                    hold_d  = GAP_LOAD;
                    state_d = HOLD;
                end else begin
                    tmo_d = tmo_q - 32'd1;
                end
            end
            HOLD: begin
                // Leaving on the 1->0 step gives exactly GAP_CYC holdoff cycles.
                if (hold_q <= 32'd1) begin
                    hold_d = '0;
                    if (retry_pend_q) begin
                        retry_pend_d = 1'b0;
                        dht_start_d  = 1'b1;
                        state_d      = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (req || period_hit) begin
            pending_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            period_q      <= '0;
            tmo_q         <= '0;
            hold_q        <= '0;
            retry_q       <= '0;
            pending_q     <= 1'b0;
            retry_pend_q  <= 1'b0;
            dht_start_q   <= 1'b0;
            humidity_q    <= '0;
            temperature_q <= '0;
            data_valid_q  <= 1'b0;
            update_q      <= 1'b0;
            error_q       <= 1'b0;
            err_count_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            tmo_q         <= tmo_d;
            hold_q        <= hold_d;
            retry_q       <= retry_d;
            pending_q     <= pending_d;
            retry_pend_q  <= retry_pend_d;
            dht_start_q   <= dht_start_d;
            humidity_q    <= humidity_d;
            temperature_q <= temperature_d;
            data_valid_q  <= data_valid_d;
            update_q      <= update_d;
            error_q       <= error_d;
            err_count_q   <= err_count_d;
            busy_q        <= busy_d;
        end
    end

    assign dht_start   = dht_start_q;
    assign humidity    = humidity_q;
    assign temperature = temperature_q;
    assign data_valid  = data_valid_q;
    assign update      = update_q;
    assign error       = error_q;
    assign err_count   = err_count_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_dht11_scheduler.sv
// Bench for dht11_scheduler: scripted/random controller responses, outcome
// and start-pulse timing predicted per read from the attempt list.
module tb_dht11_scheduler;

    localparam int PERIOD = 1000;
    localparam int T      = 200;
    localparam int GAP    = 50;
    localparam int MR     = 2;

    localparam int K_VALID = 0;
    localparam int K_BAD   = 1;
    localparam int K_NONE  = 2;

    typedef struct {
        int          kind;
        int          delay;
        logic [15:0] hum;
        logic [15:0] tmp;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst, enable, req;
    logic        dht_start, dht_done, dht_valid;
    logic [15:0] dht_humidity, dht_temperature;
    logic [15:0] humidity, temperature;
    logic        data_valid, update, error, busy;
    logic [7:0]  err_count;
    logic [2:0]  state_dbg;

    dht11_scheduler #(
        .PERIOD_CYC (PERIOD),
        .TIMEOUT_CYC(T),
        .GAP_CYC    (GAP),
        .MAX_RETRY  (MR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .req            (req),
        .dht_start      (dht_start),
        .dht_done       (dht_done),
        .dht_valid      (dht_valid),
        .dht_humidity   (dht_humidity),
        .dht_temperature(dht_temperature),
        .humidity       (humidity),
        .temperature    (temperature),
        .data_valid     (data_valid),
        .update         (update),
        .error          (error),
        .err_count      (err_count),
        .busy           (busy),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: start pulse times and pulse counts (written only here).
    int   start_times[$];
    int   upd_seen = 0;
    int   err_seen = 0;
    int   upd_dbl  = 0;
    logic upd_prev = 1'b0;
    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (dht_start === 1'b1) start_times.push_back(cyc);
            if (update === 1'b1) upd_seen++;
            if (update === 1'b1 && upd_prev === 1'b1) upd_dbl++;
            if (error === 1'b1) err_seen++;
            upd_prev = update;
        end
    end

    // Controller model: answers each start from resp_q after r.delay cycles.
    resp_t resp_q[$];
    initial begin : ctrl_model
        resp_t r;
        dht_done = 1'b0;
        dht_valid = 1'b0;
        dht_humidity = '0;
        dht_temperature = '0;
        forever begin
            @(posedge clk); #1;
            dht_valid       = 1'($urandom_range(0, 1));
            dht_humidity    = 16'($urandom);
            dht_temperature = 16'($urandom);
            if (dht_start === 1'b1 && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                if (r.kind != K_NONE) begin
                    repeat (r.delay) @(posedge clk);
                    #1;
                    dht_done        = 1'b1;
                    dht_valid       = (r.kind == K_VALID);
                    dht_humidity    = r.hum;
                    dht_temperature = r.tmp;
                    @(posedge clk); #1;
                    dht_done = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    logic [15:0] exp_hum = '0;
    logic [15:0] exp_tmp = '0;
    logic        exp_dv  = 1'b0;
    int          exp_errc = 0;
    resp_t       plan[$];

    function automatic int attempt_len(input resp_t r);
        return ((r.kind == K_NONE) ? T : r.delay) + 1 + GAP;
    endfunction

    function automatic resp_t mk(input int kind, input int delay, input logic [15:0] h, input logic [15:0] t);
        resp_t r;
        r.kind = kind; r.delay = delay; r.hum = h; r.tmp = t;
        return r;
    endfunction

    task automatic pulse_req();
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " humidity"}, 32'(humidity), 32'(exp_hum));
        check({tag, " temperature"}, 32'(temperature), 32'(exp_tmp));
        check({tag, " data_valid"}, 32'(data_valid), 32'(exp_dv));
        check({tag, " err_count"}, 32'(err_count), (exp_errc > 255) ? 255 : exp_errc);
    endtask

    // One requested read driven by the attempt list in plan.
    task automatic do_read(input string tag);
        int att, fails, ok_idx, c0, sb, ub, eb, budget, waited;
        att = 0; fails = 0; ok_idx = -1;
        for (int i = 0; i < plan.size(); i++) begin
            att++;
            if (plan[i].kind == K_VALID) begin
                ok_idx = i;
                break;
            end
            fails++;
            if (fails == 1 + MR) break;
        end
        if (ok_idx >= 0) begin
            exp_hum = plan[ok_idx].hum;
            exp_tmp = plan[ok_idx].tmp;
            exp_dv  = 1'b1;
        end else begin
            exp_errc++;
        end
        resp_q = plan;
        sb = start_times.size(); ub = upd_seen; eb = err_seen;
        c0 = cyc;
        pulse_req();
        budget = att * (T + GAP + 4) + 20;
        waited = 0;
        while ((busy === 1'b1 || start_times.size() == sb) && waited < budget) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, " finished"}, 32'(waited < budget), 1);
        check({tag, " starts"}, start_times.size() - sb, att);
        if (start_times.size() > sb)
            check({tag, " first_start"}, start_times[sb], c0 + 2);
        for (int i = 1; i < att; i++) begin
            if (start_times.size() > sb + i)
                check({tag, " spacing"}, start_times[sb + i] - start_times[sb + i - 1], attempt_len(plan[i - 1]));
        end
        check({tag, " updates"}, upd_seen - ub, (ok_idx >= 0) ? 1 : 0);
        check({tag, " errors"}, err_seen - eb, (ok_idx >= 0) ? 0 : 1);
        check({tag, " update_width"}, upd_dbl, 0);
        check({tag, " state"}, 32'(state_dbg), 0);
        check_outputs(tag);
    endtask

    initial begin : main
        int c0, sb, ub, waited;
        rst = 1'b1; enable = 1'b0; req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst dht_start", 32'(dht_start), 0);
        check("rst update", 32'(update), 0);
        check("rst error", 32'(error), 0);
        check("rst busy", 32'(busy), 0);
        check("rst state", 32'(state_dbg), 0);
        check_outputs("rst");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: single manual read
        plan.delete();
        plan.push_back(mk(K_VALID, 20, 16'h3200, 16'h1900));
        do_read("t1");

        // 2: periodic mode
        plan.delete();
        for (int i = 0; i < 3; i++) plan.push_back(mk(K_VALID, 20, 16'($urandom), 16'($urandom)));
        resp_q = plan;
        sb = start_times.size(); ub = upd_seen;
        c0 = cyc;
        enable = 1'b1;
        repeat (3500) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (1500) @(posedge clk);
        #1;
        check("t2 starts", start_times.size() - sb, 3);
        for (int i = 0; i < 3; i++)
            if (start_times.size() > sb + i)
                check("t2 start_time", start_times[sb + i] - c0, 1001 + 1000 * i);
        check("t2 updates", upd_seen - ub, 3);
        exp_hum = plan[2].hum; exp_tmp = plan[2].tmp;
        check_outputs("t2");

        // 3: two bad checksums then good
        plan.delete();
        plan.push_back(mk(K_BAD, 20, 16'h1111, 16'h2222));
        plan.push_back(mk(K_BAD, 20, 16'h3333, 16'h4444));
        plan.push_back(mk(K_VALID, 20, 16'h2D00, 16'h1700));
        do_read("t3");

        // 4: no answer at all
        plan.delete();
        for (int i = 0; i < 3; i++) plan.push_back(mk(K_NONE, 0, 16'h0, 16'h0));
        do_read("t4");

        // 5: triggers during WAIT coalesce into one extra read
        plan.delete();
        plan.push_back(mk(K_VALID, 20, 16'hA1A2, 16'hB1B2));
        plan.push_back(mk(K_VALID, 20, 16'hC1C2, 16'hD1D2));
        resp_q = plan;
        sb = start_times.size(); ub = upd_seen;
        pulse_req();
        waited = 0;
        while (start_times.size() == sb && waited < 10) begin
            @(posedge clk); #1; waited++;
        end
        repeat (5) @(posedge clk);
        #1;
        pulse_req();
        repeat (2) @(posedge clk);
        #1;
        pulse_req();
        repeat (2) @(posedge clk);
        #1;
        pulse_req();
        waited = 0;
        while ((busy === 1'b1 || start_times.size() < sb + 2) && waited < 600) begin
            @(posedge clk); #1; waited++;
        end
        check("t5 finished", 32'(waited < 600), 1);
        repeat (20) @(posedge clk);
        #1;
        check("t5 starts", start_times.size() - sb, 2);
        if (start_times.size() > sb + 1)
            check("t5 spacing", start_times[sb + 1] - start_times[sb], 20 + GAP + 2);
        check("t5 updates", upd_seen - ub, 2);
        exp_hum = 16'hC1C2; exp_tmp = 16'hD1D2;
        check_outputs("t5");

        // 5b: reset in the middle of WAIT
        plan.delete();
        plan.push_back(mk(K_VALID, 20, 16'h5555, 16'h6666));
        resp_q = plan;
        sb = start_times.size();
        pulse_req();
        waited = 0;
        while (start_times.size() == sb && waited < 10) begin
            @(posedge clk); #1; waited++;
        end
        repeat (5) @(posedge clk);
        #1;
        check("t5b in_wait", 32'(state_dbg), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_hum = '0; exp_tmp = '0; exp_dv = 1'b0; exp_errc = 0;
        check("t5b busy", 32'(busy), 0);
        check("t5b state", 32'(state_dbg), 0);
        check("t5b update", 32'(update), 0);
        check_outputs("t5b");
        sb = start_times.size();
        repeat (100) @(posedge clk);
        #1;
        check("t5b no_start", start_times.size() - sb, 0);
        check_outputs("t5b late");

        // random reads
        for (int n = 0; n < 20; n++) begin
            plan.delete();
            for (int i = 0; i < 1 + MR; i++) begin
                int k;
                k = $urandom_range(0, 2);
                plan.push_back(mk(k, $urandom_range(1, T), 16'($urandom), 16'($urandom)));
                if (k == K_VALID) break;
            end
            do_read("rnd");
        end

        // 6: saturation of err_count
        for (int n = 0; n < 256; n++) begin
            plan.delete();
            for (int i = 0; i < 1 + MR; i++) plan.push_back(mk(K_BAD, 1, 16'h0, 16'h0));
            do_read("sat");
        end
        check("sat err_count", 32'(err_count), 255);

        // 6b: done on the timeout cycle wins
        plan.delete();
        plan.push_back(mk(K_VALID, T, 16'h4321, 16'h1234));
        do_read("coinc");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
